wb_sched: RTL and testbench
===========================

# wb_sched

Writeback scheduler for the multicycle MIPS core. It accepts one writeback request per instruction and drives the writeback-mux select and register-file write strobe. For peripheral reads (source 5), it runs a request/ready handshake with the bridge, latches the device data and bounds the wait with a timeout. It sits between the control unit, the register file and the bridge, and stalls the core while a writeback is pending.

## Interface
- TIMEOUT, 16: maximum cycles `dev_req` stays high waiting for `dev_ready`; legal range 2..255.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

- clk  in  1  rising-edge clock, single domain
- rst_n  in  1  asynchronous, active-low reset
- wb_start  in  1  one-cycle pulse: begin writeback for current instruction
- wb_src  in  3  source select: 0 alu, 1 dm, 2 jalPC, 3 slt, 4 cp0, 5 bridge device; 6/7 = no write
- wb_dst  in  5  destination register number
- flush  in  1  exception/abort; cancels pending writeback
- dev_req  out  1  bridge read request
- dev_ready  in  1  bridge read data valid
- dev_rdata  in  32  bridge read data
- dev_data  out  32  latched device data, feeds mux source 5
- mem_to_reg  out  3  writeback-mux select
- reg_we  out  1  register-file write enable
- reg_waddr  out  5  register-file write address
- busy  out  1  stall to PC/control unit
- wb_done  out  1  one-cycle completion pulse
- dev_timeout  out  1  one-cycle pulse: bridge did not respond

## Operation
- States: IDLE, DEV_WAIT, WRITE, SKIP.
- IDLE + wb_start:
  - wb_src in 0..4 and wb_dst≠0 → WRITE.
  - wb_src=5 → DEV_WAIT, regardless of wb_dst; the bus read still happens for side effects.
  - wb_src in 6/7, or wb_dst=0 with wb_src≠5 → SKIP.
  - Latch wb_src into mem_to_reg and wb_dst into reg_waddr on the start edge.
- DEV_WAIT: dev_req=1; counter increments each cycle without dev_ready.
  - dev_ready → latch dev_rdata into dev_data; go to WRITE if reg_waddr≠0, else SKIP.
  - No ready and counter=TIMEOUT-1 → IDLE with wb_done=1 and dev_timeout=1; no write.
- WRITE: reg_we=1 for exactly one cycle, wb_done=1 → IDLE.
- SKIP: wb_done=1, reg_we=0 → IDLE.
- flush in DEV_WAIT/WRITE/SKIP → IDLE next edge. No reg_we, no wb_done, dev_req drops; dev_data keeps its old value.
- wb_start while not IDLE: ignored.
- busy = (state≠IDLE).
- All outputs are registered (decoded from state/latched regs), except busy, which is a state decode.

## Timing
- Reset: state IDLE. dev_req, reg_we, wb_done, dev_timeout, busy all 0. mem_to_reg=0, reg_waddr=0, dev_data=0, counter=0.
- Reset mid-transaction aborts immediately; the bridge must tolerate dev_req dropping.
- Non-device source: wb_start at edge N → reg_we/wb_done high in cycle N+1. Latency 1.
- Device source: dev_req high from cycle N+1. If dev_ready is sampled at edge M, reg_we is high in cycle M+1, with dev_data valid in the same cycle.
- Minimum device latency is 2 (ready in the first DEV_WAIT cycle). dev_req stays high at most TIMEOUT cycles.
- Simultaneous events:
  - dev_ready with the timeout count → ready wins.
  - flush with dev_ready → flush wins; data is not latched.
  - flush with wb_start in IDLE → start is ignored.
- Counter clears on DEV_WAIT entry and never wraps (saturates by construction).
- mem_to_reg and reg_waddr hold their values after completion until the next accepted wb_start.

## Structure
- Shared package wb_pkg holds:
  - Source encodings WB_ALU=0, WB_DM=1, WB_JAL=2, WB_SLT=3, WB_CP0=4, WB_DEV=5, so they match the mux select.
  - The state enum.
  - Default TIMEOUT.
- One natural sub-module, wb_timeout_cnt: a clear/enable counter with a terminal-count flag at TIMEOUT-1.

## Test plan
- wb_start, src=0, dst=8 → next cycle reg_we=1, reg_waddr=8, mem_to_reg=0, wb_done=1; busy 1 cycle.
- wb_start, src=5, dst=3; dev_ready asserted on the 3rd dev_req cycle with rdata=0xDEADBEEF → following cycle reg_we=1, dev_data=0xDEADBEEF, mem_to_reg=5.
- src=5, TIMEOUT=16, dev_ready never asserts → dev_req high exactly 16 cycles, then dev_timeout=1, wb_done=1, reg_we never 1.
- src=1, dst=0 → SKIP: wb_done=1, reg_we=0. Same with src=5, dst=0 and ready → dev_data updated, reg_we=0.
- flush in the same cycle as dev_ready during DEV_WAIT → IDLE, no reg_we, no wb_done, dev_data unchanged. Second wb_start while busy is ignored.
- rst_n low during DEV_WAIT → all outputs 0 asynchronously. After release, a new src=2 request completes in 1 cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback scheduler: mux source encodings,
// scheduler states and the default device timeout.
package wb_pkg;

    localparam int WB_TIMEOUT_DEF = 16;
    localparam int WB_CNT_W_DEF   = 8;

    // Encodings double as the writeback-mux select value.
    localparam logic [2:0] WB_ALU = 3'd0;
    localparam logic [2:0] WB_DM  = 3'd1;
    localparam logic [2:0] WB_JAL = 3'd2;
    localparam logic [2:0] WB_SLT = 3'd3;
    localparam logic [2:0] WB_CP0 = 3'd4;
    localparam logic [2:0] WB_DEV = 3'd5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEV_WAIT = 2'd1,
        WRITE    = 2'd2,
        SKIP     = 2'd3
    } wb_state_e;

    // Sources that produce a register write without a bus handshake.
    function automatic logic src_is_local(input logic [2:0] src);
        return (src <= WB_CP0);
    endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Clear/enable cycle counter with a terminal-count flag at TIMEOUT-1.
// Stops at the terminal count, so it can never wrap.
module wb_timeout_cnt #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt_reg;

    assign tc = (cnt_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && !tc) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/wb_sched.sv
// Writeback scheduler: sequences register-file writes and, for bridge-device
// sources, a bounded request/ready read before the write.
module wb_sched
    import wb_pkg::*;
#(
    parameter int TIMEOUT = WB_TIMEOUT_DEF,
    parameter int CNT_W   = WB_CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_start,
    input  logic [2:0]  wb_src,
    input  logic [4:0]  wb_dst,
    input  logic        flush,
    output logic        dev_req,
    input  logic        dev_ready,
    input  logic [31:0] dev_rdata,
    output logic [31:0] dev_data,
    output logic [2:0]  mem_to_reg,
    output logic        reg_we,
    output logic [4:0]  reg_waddr,
    output logic        busy,
    output logic        wb_done,
    output logic        dev_timeout
);

    wb_state_e   state_reg, state_next;
    logic        dev_req_reg, reg_we_reg, wb_done_reg, dev_timeout_reg;
    logic [2:0]  mem_to_reg_reg;
    logic [4:0]  reg_waddr_reg;
    logic [31:0] dev_data_reg;

    logic cnt_clr, cnt_en, cnt_tc;
    logic accept, dev_latch, timeout_hit;

    wb_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_next  = state_reg;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        accept      = 1'b0;
        dev_latch   = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                // Holding the counter clear here makes every DEV_WAIT entry start at zero.
                cnt_clr = 1'b1;
                if (wb_start && !flush) begin
                    accept = 1'b1;
                    if (wb_src == WB_DEV) begin
                        state_next = DEV_WAIT;
                    end else if (src_is_local(wb_src) && (wb_dst != 5'd0)) begin
                        state_next = WRITE;
                    end else begin
                        state_next = SKIP;
                    end
                end
            end
            DEV_WAIT: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (dev_ready) begin
                    dev_latch  = 1'b1;
                    state_next = (reg_waddr_reg != 5'd0) ? WRITE : SKIP;
                end else if (cnt_tc) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            WRITE:   state_next = IDLE;
            SKIP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            dev_req_reg     <= 1'b0;
            reg_we_reg      <= 1'b0;
            wb_done_reg     <= 1'b0;
            dev_timeout_reg <= 1'b0;
            mem_to_reg_reg  <= '0;
            reg_waddr_reg   <= '0;
            dev_data_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            dev_req_reg     <= (state_next == DEV_WAIT);
            reg_we_reg      <= (state_next == WRITE);
            wb_done_reg     <= (state_next == WRITE) || (state_next == SKIP) || timeout_hit;
            dev_timeout_reg <= timeout_hit;
            if (accept) begin
                mem_to_reg_reg <= wb_src;
                reg_waddr_reg  <= wb_dst;
            end
            if (dev_latch) begin
                dev_data_reg <= dev_rdata;
            end
        end
    end

    assign dev_req     = dev_req_reg;
    assign reg_we      = reg_we_reg;
    assign wb_done     = wb_done_reg;
    assign dev_timeout = dev_timeout_reg;
    assign mem_to_reg  = mem_to_reg_reg;
    assign reg_waddr   = reg_waddr_reg;
    assign dev_data    = dev_data_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_wb_sched.sv
// Directed self-checking bench for wb_sched with hand-computed expectations.
module tb_wb_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_start = 1'b0;
    logic [2:0]  wb_src = '0;
    logic [4:0]  wb_dst = '0;
    logic        flush = 1'b0;
    logic        dev_req;
    logic        dev_ready = 1'b0;
    logic [31:0] dev_rdata = '0;
    logic [31:0] dev_data;
    logic [2:0]  mem_to_reg;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic        busy;
    logic        wb_done;
    logic        dev_timeout;

    int checks = 0;
    int errors = 0;

    wb_sched #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_start    (wb_start),
        .wb_src      (wb_src),
        .wb_dst      (wb_dst),
        .flush       (flush),
        .dev_req     (dev_req),
        .dev_ready   (dev_ready),
        .dev_rdata   (dev_rdata),
        .dev_data    (dev_data),
        .mem_to_reg  (mem_to_reg),
        .reg_we      (reg_we),
        .reg_waddr   (reg_waddr),
        .busy        (busy),
        .wb_done     (wb_done),
        .dev_timeout (dev_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick;
        checks++;
        if ({dev_req, reg_we, wb_done, dev_timeout, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 00000", {dev_req, reg_we, wb_done, dev_timeout, busy});
        end
        checks++;
        if ({mem_to_reg, reg_waddr, dev_data} !== 40'h0) begin
            errors++;
            $display("FAIL reset_regs got %h exp 0", {mem_to_reg, reg_waddr, dev_data});
        end
        rst_n = 1'b1;
        tick;
        $display("txn reset: busy=%b reg_we=%b", busy, reg_we);
    endtask

    task automatic test_alu;
        wb_start = 1'b1; wb_src = 3'd0; wb_dst = 5'd8;
        tick;
        wb_start = 1'b0;
        checks++;
        if ({reg_we, wb_done, busy, reg_waddr, mem_to_reg} !== {3'b111, 5'd8, 3'd0}) begin
            errors++;
            $display("FAIL alu_write got we=%b done=%b busy=%b waddr=%0d m2r=%0d exp 1 1 1 8 0",
                     reg_we, wb_done, busy, reg_waddr, mem_to_reg);
        end
        tick;
        checks++;
        if ({reg_we, wb_done, busy, reg_waddr} !== {3'b000, 5'd8}) begin
            errors++;
            $display("FAIL alu_after got we=%b done=%b busy=%b waddr=%0d exp 0 0 0 8",
                     reg_we, wb_done, busy, reg_waddr);
        end
        $display("txn alu: src=0 dst=8 done");
    endtask

    task automatic test_dev_read;
        wb_start = 1'b1; wb_src = 3'd5; wb_dst = 5'd3;
        tick;
        wb_start = 1'b0;
        tick;
        tick;
        checks++;
        if ({dev_req, busy, reg_we} !== 3'b110) begin
            errors++;
            $display("FAIL dev_wait3 got req=%b busy=%b we=%b exp 1 1 0", dev_req, busy, reg_we);
        end
        dev_ready = 1'b1; dev_rdata = 32'hDEADBEEF;
        tick;
        dev_ready = 1'b0;
        checks++;
        if ({reg_we, wb_done, dev_req, mem_to_reg, reg_waddr, dev_data} !==
            {3'b110, 3'd5, 5'd3, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL dev_write got we=%b done=%b req=%b m2r=%0d waddr=%0d data=%h exp 1 1 0 5 3 deadbeef",
                     reg_we, wb_done, dev_req, mem_to_reg, reg_waddr, dev_data);
        end
        tick;
        $display("txn dev_read: data=%h", dev_data);
    endtask

    task automatic test_timeout;
        int n;
        logic we_seen;
        n = 0;
        we_seen = 1'b0;
        wb_start = 1'b1; wb_src = 3'd5; wb_dst = 5'd7;
        tick;
        wb_start = 1'b0;
        while (dev_req && n < 40) begin
            n++;
            if (reg_we || wb_done || dev_timeout) we_seen = 1'b1;
            tick;
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL timeout_req_cycles got %0d exp 16", n);
        end
        checks++;
        if ({dev_timeout, wb_done, reg_we, busy, we_seen} !== 5'b11000) begin
            errors++;
            $display("FAIL timeout_pulse got to=%b done=%b we=%b busy=%b early=%b exp 1 1 0 0 0",
                     dev_timeout, wb_done, reg_we, busy, we_seen);
        end
        tick;
        checks++;
        if ({dev_timeout, wb_done} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_one_cycle got to=%b done=%b exp 0 0", dev_timeout, wb_done);
        end
        $display("txn timeout: req_cycles=%0d", n);
    endtask

    task automatic test_skip;
        wb_start = 1'b1; wb_src = 3'd1; wb_dst = 5'd0;
        tick;
        wb_start = 1'b0;
        checks++;
        if ({wb_done, reg_we, busy} !== 3'b101) begin
            errors++;
            $display("FAIL skip_dst0 got done=%b we=%b busy=%b exp 1 0 1", wb_done, reg_we, busy);
        end
        tick;
        wb_start = 1'b1; wb_src = 3'd6; wb_dst = 5'd5;
        tick;
        wb_start = 1'b0;
        checks++;
        if ({wb_done, reg_we, mem_to_reg} !== {2'b10, 3'd6}) begin
            errors++;
            $display("FAIL skip_src6 got done=%b we=%b m2r=%0d exp 1 0 6", wb_done, reg_we, mem_to_reg);
        end
        tick;
        wb_start = 1'b1; wb_src = 3'd5; wb_dst = 5'd0;
        tick;
        wb_start = 1'b0;
        dev_ready = 1'b1; dev_rdata = 32'h12345678;
        tick;
        dev_ready = 1'b0;
        checks++;
        if ({wb_done, reg_we, dev_data} !== {2'b10, 32'h12345678}) begin
            errors++;
            $display("FAIL skip_dev got done=%b we=%b data=%h exp 1 0 12345678", wb_done, reg_we, dev_data);
        end
        tick;
        $display("txn skip: three skips done");
    endtask

    task automatic test_flush;
        wb_start = 1'b1; wb_src = 3'd5; wb_dst = 5'd9;
        tick;
        wb_start = 1'b0;
        dev_ready = 1'b1; flush = 1'b1; dev_rdata = 32'hCAFEF00D;
        tick;
        dev_ready = 1'b0; flush = 1'b0;
        checks++;
        if ({dev_req, busy, reg_we, wb_done, dev_data} !== {4'b0000, 32'h12345678}) begin
            errors++;
            $display("FAIL flush_ready got req=%b busy=%b we=%b done=%b data=%h exp 0 0 0 0 12345678",
                     dev_req, busy, reg_we, wb_done, dev_data);
        end
        tick;
        checks++;
        if ({reg_we, wb_done} !== 2'b00) begin
            errors++;
            $display("FAIL flush_after got we=%b done=%b exp 0 0", reg_we, wb_done);
        end
        wb_start = 1'b1; wb_src = 3'd5; wb_dst = 5'd4;
        tick;
        wb_src = 3'd0; wb_dst = 5'd10;
        tick;
        wb_start = 1'b0;
        checks++;
        if ({dev_req, reg_we, reg_waddr, mem_to_reg} !== {2'b10, 5'd4, 3'd5}) begin
            errors++;
            $display("FAIL busy_start_ignored got req=%b we=%b waddr=%0d m2r=%0d exp 1 0 4 5",
                     dev_req, reg_we, reg_waddr, mem_to_reg);
        end
        dev_ready = 1'b1; dev_rdata = 32'h0BADF00D;
        tick;
        dev_ready = 1'b0;
        checks++;
        if ({reg_we, reg_waddr, dev_data} !== {1'b1, 5'd4, 32'h0BADF00D}) begin
            errors++;
            $display("FAIL busy_complete got we=%b waddr=%0d data=%h exp 1 4 0badf00d",
                     reg_we, reg_waddr, dev_data);
        end
        tick;
        wb_start = 1'b1; flush = 1'b1; wb_src = 3'd0; wb_dst = 5'd12;
        tick;
        wb_start = 1'b0; flush = 1'b0;
        checks++;
        if ({busy, reg_we, reg_waddr} !== {2'b00, 5'd4}) begin
            errors++;
            $display("FAIL flush_start_idle got busy=%b we=%b waddr=%0d exp 0 0 4", busy, reg_we, reg_waddr);
        end
        $display("txn flush: scenarios done");
    endtask

    task automatic test_async_reset;
        wb_start = 1'b1; wb_src = 3'd5; wb_dst = 5'd3;
        tick;
        wb_start = 1'b0;
        checks++;
        if (dev_req !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre got req=%b exp 1", dev_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dev_req, reg_we, wb_done, dev_timeout, busy, mem_to_reg, reg_waddr, dev_data} !== 45'h0) begin
            errors++;
            $display("FAIL areset_outputs got req=%b we=%b done=%b to=%b busy=%b m2r=%0d waddr=%0d data=%h exp all 0",
                     dev_req, reg_we, wb_done, dev_timeout, busy, mem_to_reg, reg_waddr, dev_data);
        end
        tick;
        rst_n = 1'b1;
        tick;
        wb_start = 1'b1; wb_src = 3'd2; wb_dst = 5'd31;
        tick;
        wb_start = 1'b0;
        checks++;
        if ({reg_we, wb_done, mem_to_reg, reg_waddr} !== {2'b11, 3'd2, 5'd31}) begin
            errors++;
            $display("FAIL areset_jal got we=%b done=%b m2r=%0d waddr=%0d exp 1 1 2 31",
                     reg_we, wb_done, mem_to_reg, reg_waddr);
        end
        tick;
        $display("txn async_reset: recovery done");
    endtask

    initial begin
        test_reset;
        test_alu;
        test_dev_read;
        test_timeout;
        test_skip;
        test_flush;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
